// File: rtl/bus_pkg.sv
// Shared encodings for the data-RAM bus responder: FSM states and bus field values.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic HTRANS_IDLE = 1'b0;
  localparam logic HTRANS_REQ  = 1'b1;

  localparam int unsigned WORD_BYTES = 8;

endpackage

// File: rtl/ahb_ram_slave_if.sv
// Bus bundle between the memory-access stage (master) and the data RAM responder (slave).
interface ahb_ram_slave_if;

  logic [63:0] HADDR;
  logic        HWRITE;
  logic        HTRANS;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HWRITE, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ram_sp64.sv
// Single-port 64-bit data RAM with synchronous read; a write cycle returns the old word.
module ram_sp64 #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ahb_ram_slave.sv
// Bus responder for the on-chip data RAM window: decode, programmable wait states,
// two-cycle error response and a write-to-read bypass around the single-port RAM.
//
// state | meaning
// IDLE  | no data phase in progress, ready for an address phase
// WAIT  | OKAY transfer stalling, HREADY low, counter running down
// DATA  | OKAY data phase completes this cycle (read data out / write commits)
// ERR1  | first error cycle, HREADY low, HRESP high
// ERR2  | second error cycle, HREADY high, HRESP high
module ahb_ram_slave
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  ahb_ram_slave_if.slave  bus
);

  localparam logic [63:0] WIN_BYTES = 64'(WORD_BYTES) << ADDR_WIDTH;
  localparam logic        NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic                  req, hready, accept, addr_err;
  logic [63:0]           offset;
  logic [ADDR_WIDTH-1:0] addr_idx;

  logic                  rd_issue, wr_done;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  new_hit, pend_hit;

  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_idx_q;
  logic [63:0]           pend_data_q;
  logic                  byp_valid_q;
  logic [63:0]           byp_data_q;
  logic [63:0]           hold_q;
  logic [63:0]           hrdata;

  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [63:0]           ram_wdata, ram_rdata;

  always_comb begin
    req = 1'b0;
    case (bus.HTRANS)
      HTRANS_REQ:  req = 1'b1;
      HTRANS_IDLE: req = 1'b0;
      default:     req = 1'b0;
    endcase
  end

  // Window decode; the subtraction wraps for addresses below the base, which the
  // explicit below-base term catches.
  assign offset   = bus.HADDR - BASE_ADDR;
  assign addr_err = (bus.HADDR < BASE_ADDR) | (offset >= WIN_BYTES) | (bus.HADDR[2:0] != 3'b000);
  assign addr_idx = offset[ADDR_WIDTH+2:3];

  assign hready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign accept = req && hready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          wr_d  = bus.HWRITE;
          idx_d = addr_idx;
          if (addr_err)     state_d = ST_ERR1;
          else if (NO_WAIT) state_d = ST_DATA;
          else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
    endcase
  end

  // The read is launched on the edge that enters DATA. When a write completes on that
  // same edge the single port is taken by the read, so the write is parked in the
  // pending slot and committed on the next edge that carries no read.
  assign rd_issue = (accept && !addr_err && !bus.HWRITE && NO_WAIT) ||
                    (state_q == ST_WAIT && cnt_q == 4'd0 && !wr_q);
  assign rd_idx   = (state_q == ST_WAIT) ? idx_q : addr_idx;
  assign wr_done  = (state_q == ST_DATA) && wr_q;

  assign ram_we    = !rd_issue && (wr_done || pend_valid_q);
  assign ram_en    = rd_issue || ram_we;
  assign ram_addr  = rd_issue ? rd_idx : (wr_done ? idx_q : pend_idx_q);
  assign ram_wdata = wr_done ? bus.HWDATA : pend_data_q;

  assign new_hit  = wr_done && (idx_q == rd_idx);
  assign pend_hit = pend_valid_q && (pend_idx_q == rd_idx);

  ram_sp64 #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .CLK   (CLK),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    hrdata = hold_q;
    case (state_q)
      ST_ERR1, ST_ERR2: hrdata = 64'd0;
      ST_DATA: begin
        if (!wr_q) hrdata = byp_valid_q ? byp_data_q : ram_rdata;
      end
      default: hrdata = hold_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_data_q  <= 64'd0;
      byp_valid_q  <= 1'b0;
      byp_data_q   <= 64'd0;
      hold_q       <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      hold_q  <= hrdata;
      if (rd_issue) begin
        byp_valid_q <= new_hit || pend_hit;
        byp_data_q  <= new_hit ? bus.HWDATA : pend_data_q;
      end
      if (rd_issue && wr_done) begin
        pend_valid_q <= 1'b1;
        pend_idx_q   <= idx_q;
        pend_data_q  <= bus.HWDATA;
      end else if (ram_we && !wr_done) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: two instances (no wait states, three wait states) driven
// one at a time, checked every cycle against a transfer-level model.
module tb_ahb_ram_slave;

  localparam int          AW    = 10;
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE3 = 64'h1000;
  localparam logic [63:0] WIN   = 64'd8192;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0] haddr = 64'd0;
  logic [63:0] hwdata = 64'd0;
  logic        hwrite = 1'b0;
  logic        htrans = 1'b0;
  logic        sel = 1'b0;

  ahb_ram_slave_if bus0();
  ahb_ram_slave_if bus3();

  assign bus0.HADDR  = haddr;
  assign bus0.HWRITE = hwrite;
  assign bus0.HWDATA = hwdata;
  assign bus0.HTRANS = htrans & ~sel;
  assign bus3.HADDR  = haddr;
  assign bus3.HWRITE = hwrite;
  assign bus3.HWDATA = hwdata;
  assign bus3.HTRANS = htrans & sel;

  ahb_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0));
  ahb_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus3));

  logic        o_ready, o_resp;
  logic [63:0] o_rdata;
  assign o_ready = sel ? bus3.HREADY : bus0.HREADY;
  assign o_resp  = sel ? bus3.HRESP  : bus0.HRESP;
  assign o_rdata = sel ? bus3.HRDATA : bus0.HRDATA;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one transfer in its data phase with a count of cycles left.
  logic [63:0] mem_m [2][1024];
  bit          known_m [2][1024];
  logic [63:0] hold_m [2];
  bit          hold_known [2];
  int          m_left;
  bit          m_err, m_wr;
  int          m_idx;

  task automatic model_step();
    logic [63:0] base, off;
    bit rdy, e;
    int w;
    if (!RST_N) begin
      m_left = 0;
      hold_m[0] = 64'd0; hold_m[1] = 64'd0;
      hold_known[0] = 1'b1; hold_known[1] = 1'b1;
      return;
    end
    base = sel ? BASE3 : BASE0;
    w    = sel ? 3 : 0;
    rdy  = (m_left <= 1);
    if (m_left == 1) begin
      if (m_err) begin
        hold_m[sel] = 64'd0;
        hold_known[sel] = 1'b1;
      end else if (m_wr) begin
        mem_m[sel][m_idx] = hwdata;
        known_m[sel][m_idx] = 1'b1;
      end else begin
        hold_m[sel] = mem_m[sel][m_idx];
        hold_known[sel] = known_m[sel][m_idx];
      end
      m_left = 0;
    end else if (m_left > 1) begin
      m_left--;
    end
    if (rdy && htrans) begin
      off    = haddr - base;
      e      = (haddr < base) || (off >= WIN) || (haddr[2:0] != 3'b000);
      m_err  = e;
      m_wr   = hwrite;
      m_idx  = int'(off[12:3]);
      m_left = e ? 2 : w + 1;
    end
  endtask

  task automatic compare_cycle();
    bit er, es, ek;
    logic [63:0] ed;
    er = (m_left <= 1);
    es = (m_left > 0) && m_err;
    if (es) begin
      ed = 64'd0; ek = 1'b1;
    end else if (m_left == 1 && !m_wr) begin
      ed = mem_m[sel][m_idx]; ek = known_m[sel][m_idx];
    end else begin
      ed = hold_m[sel]; ek = hold_known[sel];
    end
    chk("hready", 64'(o_ready), 64'(er));
    chk("hresp", 64'(o_resp), 64'(es));
    if (ek) chk("hrdata", o_rdata, ed);
  endtask

  initial begin
    m_left = 0;
    hold_m[0] = 64'd0; hold_m[1] = 64'd0;
    hold_known[0] = 1'b1; hold_known[1] = 1'b1;
    forever begin
      @(posedge CLK or negedge RST_N);
      model_step();
    end
  end

  initial forever begin
    @(negedge CLK);
    compare_cycle();
  end

  // Presents an address phase (holding it through HREADY low) and then drives the
  // write data for the data phase. All driver tasks start and end 1 ns after a posedge.
  task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d, output int waited);
    int n;
    logic rdy;
    n = 0;
    haddr = a; hwrite = w; htrans = 1'b1;
    rdy = 1'b0;
    while (!rdy) begin
      rdy = o_ready;
      @(posedge CLK); #1;
      if (!rdy) begin
        n++;
        if (n > 40) begin
          total++; bad++;
          $display("FAIL accept_timeout: waited %0d cycles for addr %h", n, a);
          rdy = 1'b1;
        end
      end
    end
    waited = n;
    htrans = 1'b0;
    if (w) hwdata = d;
  endtask

  task automatic idle(input int n);
    htrans = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic count_lows(output int lows);
    lows = 0;
    while (!o_ready && lows < 20) begin
      lows++;
      @(posedge CLK); #1;
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'h0BAD_F000 + 32'(i * 7)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, lows, r, k;
    logic [63:0] a, base, d;
    logic wr;

    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("rst_hready", 64'(o_ready), 64'd1);
    chk("rst_hresp", 64'(o_resp), 64'd0);
    chk("rst_hrdata", o_rdata, 64'd0);

    // write then back-to-back read of the same word
    issue(64'h10, 1'b1, 64'hDEAD_BEEF_0000_0001, w);
    issue(64'h10, 1'b0, 64'd0, w);
    chk("bypass_rdata", o_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("bypass_ready", 64'(o_ready), 64'd1);
    idle(2);
    chk("idle_hold", o_rdata, 64'hDEAD_BEEF_0000_0001);

    // misaligned and out-of-window accesses
    issue(64'h08, 1'b1, 64'h0123_4567_89AB_CDEF, w);
    issue(64'h0C, 1'b1, 64'hFFFF_0000_FFFF_0000, w);
    chk("err1_ready", 64'(o_ready), 64'd0);
    chk("err1_resp", 64'(o_resp), 64'd1);
    chk("err1_rdata", o_rdata, 64'd0);
    idle(1);
    chk("err2_ready", 64'(o_ready), 64'd1);
    chk("err2_resp", 64'(o_resp), 64'd1);
    issue(64'h2000, 1'b1, 64'hFFFF_0000_FFFF_0000, w);
    chk("oow_resp", 64'(o_resp), 64'd1);
    idle(3);
    issue(64'h08, 1'b0, 64'd0, w);
    chk("err_ram_kept", o_rdata, 64'h0123_4567_89AB_CDEF);
    idle(1);

    // pipelined stream: 8 writes then 8 reads, one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      issue(64'(i * 8), 1'b1, pat(i), w);
      chk("pipe_wr_wait", 64'(w), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      issue(64'(i * 8), 1'b0, 64'd0, w);
      chk("pipe_rd_wait", 64'(w), 64'd0);
      chk("pipe_rd_data", o_rdata, pat(i));
      chk("pipe_rd_resp", 64'(o_resp), 64'd0);
    end
    idle(2);
    chk("pipe_hold", o_rdata, pat(7));
    issue(64'h38, 1'b0, 64'd0, w);
    chk("pipe_reread", o_rdata, pat(7));
    idle(1);

    // reset cuts a write in its data phase
    issue(64'h20, 1'b1, 64'h5555_6666_7777_8888, w);
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_hready", 64'(o_ready), 64'd1);
    chk("midrst_hresp", 64'(o_resp), 64'd0);
    chk("midrst_hrdata", o_rdata, 64'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    issue(64'h20, 1'b0, 64'd0, w);
    chk("midrst_dropped", o_rdata, pat(4));
    idle(2);

    // three wait states
    sel = 1'b1;
    issue(BASE3 + 64'h18, 1'b1, 64'hFACE_0000_CAFE_0018, w);
    issue(BASE3 + 64'h18, 1'b0, 64'd0, w);
    chk("w3_wr_stall", 64'(w), 64'd3);
    haddr = BASE3 + 64'h18; hwrite = 1'b0; htrans = 1'b1;
    count_lows(lows);
    chk("w3_lows", 64'(lows), 64'd3);
    chk("w3_rdata", o_rdata, 64'hFACE_0000_CAFE_0018);
    @(posedge CLK); #1;
    htrans = 1'b0;
    count_lows(lows);
    chk("w3_held_lows", 64'(lows), 64'd3);
    chk("w3_held_rdata", o_rdata, 64'hFACE_0000_CAFE_0018);
    idle(2);
    issue(BASE3 - 64'd8, 1'b1, 64'd1, w);
    chk("w3_below_ready", 64'(o_ready), 64'd0);
    chk("w3_below_resp", 64'(o_resp), 64'd1);
    idle(4);

    // randomized traffic on each instance
    for (int s = 0; s < 2; s++) begin
      sel  = s[0];
      base = sel ? BASE3 : BASE0;
      for (int t = 0; t < 250; t++) begin
        r = int'($urandom_range(0, 11));
        k = int'($urandom_range(0, 15));
        a = base + 64'(k * 8);
        if (r == 0) a = a + 64'($urandom_range(1, 7));
        else if (r == 1) a = base + WIN + 64'($urandom_range(0, 3) * 8);
        else if (r == 2) a = base - 64'($urandom_range(1, 4) * 8);
        wr = 1'($urandom_range(0, 1));
        d  = {$urandom, $urandom};
        issue(a, wr, d, w);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
